regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two write-back requesters: the ALU/EX result path and the LSU load-return path.
- Each requester uses a valid/ready handshake. The block arbitrates round-robin and drives a registered write (we/waddr/wdata) into the register file.
- Holds a per-register pending-write scoreboard. Decode uses it for RAW hazard stalls on outstanding writes.

Parameters:
- RegNum, 32, number of architectural registers (x0 hardwired zero).
- RegAddrWidth, 5, register address width; must equal clog2(RegNum).
- RegBusWidth, 32, data width of a write.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- alu_valid_i  input  1  ALU write-back request valid
- alu_ready_o  output  1  ALU request accepted this cycle
- alu_rd_i  input  RegAddrWidth  ALU destination register
- alu_data_i  input  RegBusWidth  ALU result
- lsu_valid_i  input  1  LSU load-return request valid
- lsu_ready_o  output  1  LSU request accepted this cycle
- lsu_rd_i  input  RegAddrWidth  LSU destination register
- lsu_data_i  input  RegBusWidth  load data
- issue_i  input  1  an instruction with a register destination issues this cycle
- issue_rd_i  input  RegAddrWidth  destination of the issuing instruction
- rs1_i  input  RegAddrWidth  decode source 1
- rs2_i  input  RegAddrWidth  decode source 2
- hazard_o  output  1  a source register has a pending write; stall decode
- we_o  output  1  register-file write enable
- waddr_o  output  RegAddrWidth  register-file write address
- wdata_o  output  RegBusWidth  register-file write data

Behaviour:
- Reset (rstn low, asynchronous): we_o=0, waddr_o=0, wdata_o=0, all busy bits 0, round-robin pointer set so LSU has priority.
- Grant is combinational in cycle N: alu_ready_o / lsu_ready_o assert for the granted requester only; at most one is high.
- Single valid requester is always granted. Both valid: the requester not granted most recently wins.
- Round-robin pointer updates only on a grant made while both requesters were valid. After reset, first contention goes to LSU.
- Latency is exactly 1 cycle. A grant in cycle N drives we_o=1, waddr_o=rd and wdata_o=data in cycle N+1.
- we_o is high for exactly one cycle per accepted write. With no grant, we_o=0 and waddr_o/wdata_o hold their last values.
- Back-to-back grants give we_o high on consecutive cycles (full throughput, one write per cycle).
- Requester protocol: once valid is raised, the requester holds valid, rd and data stable until ready. The block does not check this.
- rd=0 request: accepted (ready=1) and counts for round-robin, but we_o stays 0 in N+1 and no scoreboard effect.
- Scoreboard set: issue_i=1 with issue_rd_i!=0 sets busy[issue_rd_i] at the clock edge.
- Scoreboard clear: a grant with rd!=0 clears busy[rd] at the end of grant cycle N.
  - The register file's same-cycle write bypass covers consumers reading in cycle N+1.
- Same-edge set and clear of the same register: set wins, because the newer instruction is outstanding.
- Issue to an already-busy register leaves it busy. One pending write per register is supported; issue logic guarantees in-order destinations.
- hazard_o is combinational: (rs1_i!=0 && busy[rs1_i]) || (rs2_i!=0 && busy[rs2_i]).
  - It reflects busy state before the current edge, so hazard_o=1 during the grant cycle and 0 in the following cycle.
- rstn asserted mid-operation: any accepted but not yet committed write is discarded (we_o forced 0), and the scoreboard clears.

Test Plan:
- ALU-only: alu_valid_i=1, rd=5, data=0xDEADBEEF in cycle 2 -> alu_ready_o=1 in cycle 2; in cycle 3 we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; in cycle 4 we_o=0.
- Contention after reset: both valid (ALU rd=3, LSU rd=4) for 2 cycles -> LSU granted first, then ALU; we_o high 2 consecutive cycles with waddr_o 4 then 3.
- Sustained contention for 6 cycles -> grants strictly alternate LSU/ALU and no requester waits more than 1 cycle.
- x0 drop: LSU rd=0, data=0x1234 -> lsu_ready_o=1, we_o stays 0, hazard_o unaffected.
- Scoreboard: issue rd=7; rs1_i=7 -> hazard_o=1 next cycle; LSU return rd=7 granted at cycle N -> hazard_o=1 at N, 0 at N+1. Same-edge issue rd=7 and grant rd=7 -> busy[7] remains 1.
- Async reset while a grant is pending and busy[9]=1 -> we_o=0 immediately, hazard_o=0 for rs1_i=9, LSU priority restored.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-file write port between
// the ALU and LSU write-back paths, plus a pending-write scoreboard for decode RAW stalls.
module regfile_wb_arbiter #(
    parameter int RegNum       = 32,
    parameter int RegAddrWidth = 5,
    parameter int RegBusWidth  = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    alu_valid_i,
    output logic                    alu_ready_o,
    input  logic [RegAddrWidth-1:0] alu_rd_i,
    input  logic [RegBusWidth-1:0]  alu_data_i,
    input  logic                    lsu_valid_i,
    output logic                    lsu_ready_o,
    input  logic [RegAddrWidth-1:0] lsu_rd_i,
    input  logic [RegBusWidth-1:0]  lsu_data_i,
    input  logic                    issue_i,
    input  logic [RegAddrWidth-1:0] issue_rd_i,
    input  logic [RegAddrWidth-1:0] rs1_i,
    input  logic [RegAddrWidth-1:0] rs2_i,
    output logic                    hazard_o,
    output logic                    we_o,
    output logic [RegAddrWidth-1:0] waddr_o,
    output logic [RegBusWidth-1:0]  wdata_o
);
    logic                    prio_alu;
    logic [RegNum-1:0]       busy;
    logic                    grant;
    logic [RegAddrWidth-1:0] g_rd;
    logic [RegBusWidth-1:0]  g_data;

    // prio_alu only moves on contention, so lone requests never disturb fairness
    assign alu_ready_o = alu_valid_i && (!lsu_valid_i || prio_alu);
    assign lsu_ready_o = lsu_valid_i && (!alu_valid_i || !prio_alu);
    assign grant       = alu_ready_o || lsu_ready_o;
    assign g_rd        = alu_ready_o ? alu_rd_i : lsu_rd_i;
    assign g_data      = alu_ready_o ? alu_data_i : lsu_data_i;
    assign hazard_o    = (rs1_i != '0 && busy[rs1_i]) || (rs2_i != '0 && busy[rs2_i]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio_alu <= 1'b0;
            we_o     <= 1'b0;
            waddr_o  <= '0;
            wdata_o  <= '0;
        end else begin
            if (alu_valid_i && lsu_valid_i)
                prio_alu <= lsu_ready_o;
            we_o <= grant && g_rd != '0;
            if (grant && g_rd != '0) begin
                waddr_o <= g_rd;
                wdata_o <= g_data;
            end
        end
    end

    // a same-edge issue to the register being written keeps it busy for the newer producer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            busy <= '0;
        else
            for (int i = 0; i < RegNum; i++)
                busy[i] <= i != 0 && ((issue_i && issue_rd_i == RegAddrWidth'(i)) ||
                                      (busy[i] && !(grant && g_rd == RegAddrWidth'(i))));
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random stimulus against a behavioural model
// of the write-back arbiter and scoreboard.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        alu_valid_i, lsu_valid_i, issue_i;
    logic        alu_ready_o, lsu_ready_o, hazard_o, we_o;
    logic [4:0]  alu_rd_i, lsu_rd_i, issue_rd_i, rs1_i, rs2_i, waddr_o;
    logic [31:0] alu_data_i, lsu_data_i, wdata_o;

    int checks = 0;
    int errors = 0;

    bit          busy_m [32];
    bit          last_alu;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    bit          ga, gl;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rstn(rstn),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .issue_i(issue_i), .issue_rd_i(issue_rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .hazard_o(hazard_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        last_alu  = 1'b1;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
    endtask

    task automatic idle_inputs();
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
        issue_i = 0; issue_rd_i = 0; rs1_i = 0; rs2_i = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, then check the registered write
    task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input bit iss, input logic [4:0] ird,
                         input logic [4:0] r1, input logic [4:0] r2);
        logic [4:0]  rd;
        logic [31:0] d;
        bit          hz;
        @(negedge clk);
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = adat;
        lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ldat;
        issue_i = iss; issue_rd_i = ird; rs1_i = r1; rs2_i = r2;
        #1;
        ga = av && (!lv || !last_alu);
        gl = lv && (!av || last_alu);
        hz = (r1 != 0 && busy_m[r1]) || (r2 != 0 && busy_m[r2]);
        chk("alu_ready", alu_ready_o, ga);
        chk("lsu_ready", lsu_ready_o, gl);
        chk("hazard", hazard_o, hz);
        @(posedge clk);
        #1;
        if (av && lv) last_alu = ga;
        rd = ga ? ard : lrd;
        d  = ga ? adat : ldat;
        exp_we = (ga || gl) && rd != 0;
        if (exp_we) begin
            exp_waddr = rd;
            exp_wdata = d;
            busy_m[rd] = 1'b0;
        end
        if (iss && ird != 0) busy_m[ird] = 1'b1;
        chk("we", we_o, exp_we);
        chk("waddr", waddr_o, exp_waddr);
        chk("wdata", wdata_o, exp_wdata);
    endtask

    initial begin
        bit          pa, pl;
        logic [4:0]  ar, lr;
        logic [31:0] ad, ld;
        rstn = 1'b0;
        idle_inputs();
        reset_model();
        #2;
        chk("rst_we", we_o, 1'b0);
        chk("rst_waddr", waddr_o, 5'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_hazard", hazard_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // ALU only, then idle so we_o drops
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // contention after reset: LSU then ALU
        cycle(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0);
        chk("contend1_lsu", waddr_o, 5'd4);
        cycle(1, 3, 32'h33, 1, 4, 32'h45, 0, 0, 0, 0);
        chk("contend2_alu", waddr_o, 5'd3);
        // sustained contention
        for (int i = 0; i < 6; i++)
            cycle(1, 5'(10 + i), 32'hA000 + i, 1, 5'(20 + i), 32'hB000 + i, 0, 0, 0, 0);
        // x0 drop
        cycle(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // scoreboard set/clear and same-edge set-wins
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("sb_busy7", hazard_o, 1'b1);
        cycle(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("sb_clear7", hazard_o, 1'b0);
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        cycle(0, 0, 0, 1, 7, 32'h78, 1, 7, 0, 7);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        chk("sb_setwins7", hazard_o, 1'b1);
        cycle(1, 7, 32'h79, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);

        // async reset with a write in flight and busy[9] set
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        cycle(1, 11, 32'hCAFE, 0, 0, 0, 0, 0, 9, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_we", we_o, 1'b0);
        chk("arst_hazard", hazard_o, 1'b0);
        chk("arst_waddr", waddr_o, 5'd0);
        idle_inputs();
        reset_model();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1, 1, 32'h1, 1, 2, 32'h2, 0, 0, 9, 0);
        chk("arst_lsu_prio", waddr_o, 5'd2);

        // random traffic with hold-until-ready requesters
        pa = 0; pl = 0; ar = 0; lr = 0; ad = 0; ld = 0;
        for (int n = 0; n < 300; n++) begin
            if (!pa) begin pa = 1'($urandom_range(0, 1)); ar = 5'($urandom_range(0, 31)); ad = $urandom; end
            if (!pl) begin pl = 1'($urandom_range(0, 1)); lr = 5'($urandom_range(0, 31)); ld = $urandom; end
            cycle(pa, ar, ad, pl, lr, ld, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (ga) pa = 0;
            if (gl) pl = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
